// File: rtl/shift_add_mult_ctrl.sv
// shift_add_mult_ctrl: sequential shift-add unsigned multiplier, one multiplier bit per cycle.
// Fixed latency of W cycles from the accepting edge to the done pulse.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module shift_add_mult_ctrl #(
    parameter int unsigned W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] product
);
    localparam int unsigned CW = (W > 2) ? $clog2(W) : 1;
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state;
    logic [W-1:0]  mcand;
    logic [W-1:0]  mplr;
    logic [W-1:0]  acc;
    logic [CW-1:0] cnt;
    logic [W-1:0]  sum;
    logic [W:0]    c;

    // The ripple carry-out is the bit that shifts into the accumulator MSB.
    assign c[0] = 1'b0;
    for (genvar i = 0; i < W; i++) begin : g_fa
        full_adder u_fa (
            .a  (acc[i]),
            .b  (mcand[i] & mplr[0]),
            .ci (c[i]),
            .s  (sum[i]),
            .co (c[i+1])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            mcand   <= '0;
            mplr    <= '0;
            acc     <= '0;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    mcand <= a;
                    mplr  <= b;
                    acc   <= '0;
                    cnt   <= '0;
                    busy  <= 1'b1;
                    state <= RUN;
                end
                RUN: begin
                    acc  <= {c[W], sum[W-1:1]};
                    mplr <= {sum[0], mplr[W-1:1]};
                    cnt  <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        product <= {c[W], sum, mplr[W-1:1]};
                        done    <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/shift_add_mult_ctrl.md
SHIFT_ADD_MULT_CTRL -- requirements
Module: shift_add_mult_ctrl

Interface
REQ-001 The block SHALL have parameter W, default 8, giving the operand width in bits (legal range 2..16).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin a multiply, sampled on clk rising edge.
REQ-005 The block SHALL have port a, input, W bits: unsigned multiplicand, sampled only on the accepting edge.
REQ-006 The block SHALL have port b, input, W bits: unsigned multiplier, sampled only on the accepting edge.
REQ-007 The block SHALL have port busy, output, 1 bit: high while an operation is in progress (states RUN and DONE).
REQ-008 The block SHALL have port done, output, 1 bit: single-cycle pulse marking product valid.
REQ-009 The block SHALL have port product, output, 2W bits: unsigned a*b result, registered.

Function
REQ-010 The block SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-011 In IDLE with start=1 at a rising edge (the accepting edge, edge 0), the block SHALL capture a into the multiplicand register and b into the multiplier register, clear the W-bit accumulator and carry, load the iteration counter with 0, and enter RUN.
REQ-012 In IDLE with start=0, the block SHALL hold all registers and product unchanged.
REQ-013 In RUN at each rising edge (edges 1..W), the block SHALL form {carry, sum} = accumulator + (multiplier[0] ? multiplicand : 0).
REQ-014 At the same edge, the block SHALL load {carry, sum, multiplier} shifted right by one into {accumulator, multiplier}.
REQ-015 At the same edge, the block SHALL increment the counter.
REQ-016 The RUN addition SHALL be a W-bit ripple-carry chain of the team's full-adder cells with carry-in tied to 0.
REQ-017 The carry-out of that addition SHALL be the only source of the bit shifted into the accumulator MSB.
REQ-018 At edge W (counter reaching W-1 before the edge), the block SHALL write {accumulator, multiplier} after the final shift into product and enter DONE.
REQ-019 In DONE, done SHALL be 1 for exactly one cycle (between edge W and edge W+1), and the block SHALL return to IDLE at edge W+1.
REQ-020 Latency SHALL be fixed at W cycles from the accepting edge to done=1, independent of operand values.
REQ-021 Throughput SHALL be one operation per W+2 cycles when start is held high.
REQ-022 start SHALL be ignored in RUN and DONE; in-flight operand registers SHALL NOT change if a or b change during those states.
REQ-023 product SHALL hold its value from edge W until the edge W of the next accepted operation; product SHALL NOT change in IDLE or during RUN.
REQ-024 The result SHALL equal a*b modulo 2^(2W); this never wraps for unsigned operands, so the full product SHALL always be exact.
REQ-025 done and busy SHALL be driven from registered state only, with no combinational path from start, a or b.

Reset
REQ-026 rst_n=0 SHALL force, asynchronously and regardless of clk, state=IDLE, busy=0, done=0, product=0, and accumulator, multiplier, multiplicand, carry and counter all 0.
REQ-027 Reset asserted during RUN or DONE SHALL abort the operation with no done pulse; the aborted operation SHALL leave no residue in any later result.
REQ-028 After rst_n deasserts, the first rising edge with start=1 SHALL be an accepting edge.

Verification (W=8)
REQ-029 Bench SHALL check a=0x0D, b=0x0B, start pulsed once -> busy=1 from edge 0, done=1 exactly 8 cycles later, product=0x008F, busy=0 after edge 9.
REQ-030 Bench SHALL check a=0xFF, b=0xFF -> product=0xFE01; a=0x00, b=0xFF -> product=0x0000; a=0x80, b=0x02 -> product=0x0100.
REQ-031 Bench SHALL check start=1 with a=0x03, b=0x05 accepted, then start re-pulsed mid-RUN with a=0x77 -> single done, product=0x000F, operation not restarted.
REQ-032 Bench SHALL check start held high continuously with constant a=0x12, b=0x34 -> done pulses every 10 cycles, product=0x03A8 each time.
REQ-033 Bench SHALL check rst_n pulsed low at cycle 4 of RUN (a=0xAA, b=0x55) -> immediate busy=0, done=0, product=0x0000, no done pulse; a subsequent 0x02*0x03 yields 0x0006.
REQ-034 Bench SHALL check an exhaustive 256x256 sweep against a reference model -> every product exact, every done pulse exactly one cycle wide.
